// File: rtl/alu_op_sequencer.sv
// Button-driven load sequencer for the ALU: debounces three push-buttons and
// steps operand A, operand B and opcode into the ALU registers, then captures the result.
module alu_op_sequencer #(
  parameter int NBITS      = 8,
  parameter int COD_OP     = 6,
  parameter int DEB_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        pulsador,
  input  logic [NBITS-1:0]  entrada,
  input  logic [NBITS-1:0]  alu_result,
  output logic [NBITS-1:0]  o_a,
  output logic [NBITS-1:0]  o_b,
  output logic [COD_OP-1:0] o_cod_op,
  output logic [NBITS-1:0]  o_result,
  output logic              o_valid,
  output logic [2:0]        o_estado
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_CALC = 3'd3,
    S_RES  = 3'd4
  } state_t;

  state_t state, state_n;

  logic [2:0]       sync_ff1;
  logic [2:0]       sync_ff2;
  logic [2:0]       deb;
  logic [2:0]       deb_q;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       press;

  logic [NBITS-1:0]  a_n;
  logic [NBITS-1:0]  b_n;
  logic [COD_OP-1:0] op_n;
  logic [NBITS-1:0]  res_n;
  logic              valid_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_ff1 <= '0;
      sync_ff2 <= '0;
    end else begin
      sync_ff1 <= pulsador;
      sync_ff2 <= sync_ff1;
    end
  end

  // A level change is accepted only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb   <= '0;
      deb_q <= '0;
      for (int unsigned i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb_q <= deb;
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync_ff2[i] != deb[i]) begin
          if (cnt[i] == CNT_MAX) begin
            deb[i] <= sync_ff2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = deb & ~deb_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_A;
      o_a      <= '0;
      o_b      <= '0;
      o_cod_op <= '0;
      o_result <= '0;
      o_valid  <= 1'b0;
    end else begin
      state    <= state_n;
      o_a      <= a_n;
      o_b      <= b_n;
      o_cod_op <= op_n;
      o_result <= res_n;
      o_valid  <= valid_n;
    end
  end

  // Only the press expected by the current state is acted on; all others are dropped.
  always_comb begin
    state_n = state;
    a_n     = o_a;
    b_n     = o_b;
    op_n    = o_cod_op;
    res_n   = o_result;
    valid_n = o_valid;
    case (state)
      S_A: begin
        if (press[0]) begin
          a_n     = entrada;
          state_n = S_B;
        end
      end
      S_B: begin
        if (press[1]) begin
          b_n     = entrada;
          state_n = S_OP;
        end
      end
      S_OP: begin
        if (press[2]) begin
          op_n    = entrada[COD_OP-1:0];
          state_n = S_CALC;
        end
      end
      S_CALC: begin
        res_n   = alu_result;
        valid_n = 1'b1;
        state_n = S_RES;
      end
      S_RES: begin
        if (press[0]) begin
          a_n     = entrada;
          valid_n = 1'b0;
          state_n = S_B;
        end
      end
      default: state_n = S_A;
    endcase
  end

  assign o_estado = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: table-driven load sequences, exact-latency
// checks and a state-transition scoreboard that flags any unexpected register load.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] pulsador = '0;
  logic [7:0] entrada = '0;
  logic [7:0] alu_result;
  logic [7:0] o_a;
  logic [7:0] o_b;
  logic [5:0] o_cod_op;
  logic [7:0] o_result;
  logic       o_valid;
  logic [2:0] o_estado;

  alu_op_sequencer #(.NBITS(8), .COD_OP(6), .DEB_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pulsador   (pulsador),
    .entrada    (entrada),
    .alu_result (alu_result),
    .o_a        (o_a),
    .o_b        (o_b),
    .o_cod_op   (o_cod_op),
    .o_result   (o_result),
    .o_valid    (o_valid),
    .o_estado   (o_estado)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (o_cod_op)
      6'h20:   alu_result = o_a + o_b;
      6'h22:   alu_result = o_a - o_b;
      6'h24:   alu_result = o_a & o_b;
      6'h25:   alu_result = o_a | o_b;
      default: alu_result = '0;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard entry: kind is the state reached by the load, val the register value.
  typedef struct {
    logic [2:0] kind;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  bit   mon_en = 1'b0;
  logic [2:0] st_prev = '0;

  task automatic expect_load(input logic [2:0] k, input logic [7:0] v);
    exp_t e;
    e.kind = k;
    e.val  = v;
    sbq.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n && (o_estado != st_prev) && (o_estado != 3'd0)) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got state %0d from %0d, required no transition at %0t",
                 o_estado, st_prev, $time);
      end else begin
        e = sbq.pop_front();
        check("sb_state", 32'(o_estado), 32'(e.kind));
        case (e.kind)
          3'd1: begin
            check("sb_a", 32'(o_a), 32'(e.val));
            check("sb_a_valid", 32'(o_valid), 32'd0);
          end
          3'd2: check("sb_b", 32'(o_b), 32'(e.val));
          3'd3: check("sb_op", 32'(o_cod_op), 32'(e.val));
          default: begin
            check("sb_result", 32'(o_result), 32'(e.val));
            check("sb_valid", 32'(o_valid), 32'd1);
          end
        endcase
      end
    end
    st_prev = o_estado;
  end

  // Press held from the first sampling edge k; the load must land exactly at edge k+6.
  task automatic load_exact(input logic [2:0] btn, input logic [7:0] val,
                            input logic [2:0] nxt, input logic [7:0] exp_res,
                            input string nm);
    logic [2:0] st0;
    @(posedge clk); #1;
    entrada  = val;
    st0      = o_estado;
    pulsador = btn;
    repeat (6) @(posedge clk);
    #1 check({nm, "_early"}, 32'(o_estado), 32'(st0));
    @(posedge clk);
    #1 check({nm, "_state"}, 32'(o_estado), 32'(nxt));
    if (nxt == 3'd3) begin
      check({nm, "_valid_pre"}, 32'(o_valid), 32'd0);
      @(posedge clk);
      #1 check({nm, "_res_state"}, 32'(o_estado), 32'd4);
      check({nm, "_result"}, 32'(o_result), 32'(exp_res));
      check({nm, "_valid"}, 32'(o_valid), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1 pulsador = '0;
    repeat (12) @(posedge clk);
  endtask

  task automatic press_ignored(input logic [2:0] btn, input logic [7:0] val);
    @(posedge clk); #1;
    entrada  = val;
    pulsador = btn;
    repeat (10) @(posedge clk);
    #1 pulsador = '0;
    repeat (12) @(posedge clk);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_a"}, 32'(o_a), 32'd0);
    check({nm, "_b"}, 32'(o_b), 32'd0);
    check({nm, "_op"}, 32'(o_cod_op), 32'd0);
    check({nm, "_result"}, 32'(o_result), 32'd0);
    check({nm, "_valid"}, 32'(o_valid), 32'd0);
    check({nm, "_state"}, 32'(o_estado), 32'd0);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] res;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{a: 8'h50, b: 8'h10, op: 6'h22, res: 8'h40};
    tbl[1] = '{a: 8'hF0, b: 8'h3C, op: 6'h24, res: 8'h30};
    tbl[2] = '{a: 8'hA5, b: 8'h0F, op: 6'h25, res: 8'hAF};
    tbl[3] = '{a: 8'hFF, b: 8'h02, op: 6'h20, res: 8'h01};

    // Reset with buttons toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      pulsador = 3'($urandom);
      entrada  = 8'($urandom);
    end
    check_all_zero("reset");
    pulsador = '0;
    rst_n    = 1'b1;
    repeat (12) @(posedge clk);
    #1 check("post_reset_idle", 32'(o_estado), 32'd0);
    mon_en = 1'b1;

    // 3-cycle glitch on button 0: no load
    @(posedge clk); #1;
    entrada  = 8'h99;
    pulsador = 3'b001;
    repeat (3) @(posedge clk);
    #1 pulsador = '0;
    repeat (15) @(posedge clk);
    #1 check("glitch_state", 32'(o_estado), 32'd0);
    check("glitch_a", 32'(o_a), 32'd0);

    // Out-of-order presses in S_A
    press_ignored(3'b010, 8'h11);
    press_ignored(3'b100, 8'h22);
    check("ooo_state", 32'(o_estado), 32'd0);
    check("ooo_b", 32'(o_b), 32'd0);

    // Nominal sequence
    expect_load(3'd1, 8'h0F);
    load_exact(3'b001, 8'h0F, 3'd1, 8'h00, "nom_a");
    expect_load(3'd2, 8'h03);
    load_exact(3'b010, 8'h03, 3'd2, 8'h00, "nom_b");
    expect_load(3'd3, 8'h20);
    expect_load(3'd4, 8'h12);
    load_exact(3'b100, 8'h20, 3'd3, 8'h12, "nom_op");
    check("nom_a_final", 32'(o_a), 32'h0F);
    check("nom_b_final", 32'(o_b), 32'h03);
    check("nom_op_final", 32'(o_cod_op), 32'h20);

    // Restart from S_RES, then a stray opcode press
    expect_load(3'd1, 8'hAA);
    load_exact(3'b001, 8'hAA, 3'd1, 8'h00, "restart");
    check("restart_valid", 32'(o_valid), 32'd0);
    check("restart_result_kept", 32'(o_result), 32'h12);
    press_ignored(3'b100, 8'h3F);
    check("restart_op_ignored_state", 32'(o_estado), 32'd1);
    check("restart_op_kept", 32'(o_cod_op), 32'h20);

    // Simultaneous [0]+[1] in S_B
    expect_load(3'd2, 8'h55);
    load_exact(3'b011, 8'h55, 3'd2, 8'h00, "simul");
    check("simul_b", 32'(o_b), 32'h55);
    check("simul_a_kept", 32'(o_a), 32'hAA);
    expect_load(3'd3, 8'h22);
    expect_load(3'd4, 8'h55);
    load_exact(3'b100, 8'h22, 3'd3, 8'h55, "simul_op");

    // Table-driven sequences, each restarting from S_RES
    for (int i = 0; i < 4; i++) begin
      expect_load(3'd1, tbl[i].a);
      load_exact(3'b001, tbl[i].a, 3'd1, 8'h00, "tbl_a");
      expect_load(3'd2, tbl[i].b);
      load_exact(3'b010, tbl[i].b, 3'd2, 8'h00, "tbl_b");
      expect_load(3'd3, {2'b00, tbl[i].op});
      expect_load(3'd4, tbl[i].res);
      load_exact(3'b100, {2'b11, tbl[i].op}, 3'd3, tbl[i].res, "tbl_op");
      check("tbl_op_slice", 32'(o_cod_op), 32'(tbl[i].op));
    end

    // Bouncy long press on [0] with a release bounce: exactly one load
    expect_load(3'd1, 8'h77);
    @(posedge clk); #1;
    entrada  = 8'h77;
    pulsador = 3'b001;
    @(posedge clk); #1 pulsador = '0;
    @(posedge clk); #1 pulsador = 3'b001;
    repeat (30) @(posedge clk);
    #1 pulsador = '0;
    @(posedge clk); #1 pulsador = 3'b001;
    @(posedge clk); #1 pulsador = '0;
    repeat (15) @(posedge clk);
    #1 check("bounce_state", 32'(o_estado), 32'd1);
    check("bounce_a", 32'(o_a), 32'h77);

    // Reset in S_OP with button 0 held through release
    expect_load(3'd2, 8'h11);
    load_exact(3'b010, 8'h11, 3'd2, 8'h00, "pre_rst_b");
    @(posedge clk); #1;
    rst_n    = 1'b0;
    entrada  = 8'h3C;
    pulsador = 3'b001;
    repeat (2) @(posedge clk);
    #1 check_all_zero("mid_reset");
    check("mid_reset_sb_empty", 32'(sbq.size()), 32'd0);
    rst_n = 1'b1;
    expect_load(3'd1, 8'h3C);
    repeat (6) @(posedge clk);
    #1 check("held_early_a", 32'(o_a), 32'd0);
    check("held_early_state", 32'(o_estado), 32'd0);
    @(posedge clk);
    #1 check("held_a", 32'(o_a), 32'h3C);
    check("held_state", 32'(o_estado), 32'd1);
    repeat (20) @(posedge clk);
    #1 pulsador = '0;
    repeat (15) @(posedge clk);
    #1 check("held_single_state", 32'(o_estado), 32'd1);
    check("sb_drained", 32'(sbq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
